// File: rtl/sram_ctrl.sv
// sram_ctrl: Wishbone B4 pipelined slave driving an external asynchronous SRAM.
// Wait states are derived from WB_CLOCK_MHZ and ACCESS_NS. Writes hold the
// data bus one extra cycle after WE falls so the SRAM latches stable data.
// Optional macro SRAM_CTRL_TURNAROUND_EN: after a read, spend one extra cycle
// in RECOVER so the SRAM outputs return to High-Z before the FPGA can drive
// the bus for a following write.
`timescale 1ns/1ps

module sram_ctrl #(
  parameter int WB_CLOCK_MHZ = 64,
  parameter int ACCESS_NS    = 10,
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 17,
  parameter int SEL_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  wb_clock_i,
  input  logic                  wb_reset_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic [SEL_WIDTH-1:0]  wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cycle_i,
  input  logic                  wb_strobe_i,
  output logic                  wb_stall_o,
  output logic                  wb_ack_o,
  output logic                  ram_oe_o,
  output logic                  ram_we_o,
  output logic [SEL_WIDTH-1:0]  ram_be_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  ram_data_oe
);

  // Clock cycles needed to cover the SRAM access time, never less than one.
  localparam int CYC_RAW       = (ACCESS_NS * WB_CLOCK_MHZ + 999) / 1000;
  localparam int ACCESS_CYCLES = (CYC_RAW < 1) ? 1 : CYC_RAW;
  localparam int CNT_W         = $clog2(ACCESS_CYCLES + 1);

  // Reads count one extra edge so OE covers the full access plus capture.
  localparam logic [CNT_W-1:0] CNT_READ  = CNT_W'(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_WRITE = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RECOVER} state_t;

  // Initialisers give the same power-up state as reset on FPGA targets.
  state_t                  state_reg = IDLE;
  state_t                  state_next;
  logic [CNT_W-1:0]        cnt_reg = '0;
  logic [CNT_W-1:0]        cnt_next;
  logic                    oe_reg = 1'b0;
  logic                    oe_next;
  logic                    we_reg = 1'b0;
  logic                    we_next;
  logic                    doe_reg = 1'b0;
  logic                    doe_next;
  logic                    ack_reg = 1'b0;
  logic                    ack_next;
  logic [SEL_WIDTH-1:0]    be_reg = '0;
  logic [SEL_WIDTH-1:0]    be_next;
  logic [ADDR_WIDTH-1:0]   addr_reg = '0;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [DATA_WIDTH-1:0]   wdata_reg = '0;
  logic [DATA_WIDTH-1:0]   wdata_next;
  logic [DATA_WIDTH-1:0]   rdata_reg = '0;
  logic [DATA_WIDTH-1:0]   rdata_next;

  // Next-state and output decode; everything holds unless a state says otherwise.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    oe_next    = oe_reg;
    we_next    = we_reg;
    doe_next   = doe_reg;
    ack_next   = 1'b0;
    be_next    = be_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    case (state_reg)
      IDLE: begin
        if (wb_cycle_i && wb_strobe_i) begin
          addr_next  = wb_addr_i;
          wdata_next = wb_data_i;
          be_next    = wb_sel_i;
          if (wb_we_i) begin
            we_next    = 1'b1;
            doe_next   = 1'b1;
            cnt_next   = CNT_WRITE;
            state_next = WRITE;
          end else begin
            oe_next    = 1'b1;
            cnt_next   = CNT_READ;
            state_next = READ;
          end
        end
      end
      READ: begin
        if (cnt_reg == '0) begin
          rdata_next = ram_data_i;
          oe_next    = 1'b0;
          ack_next   = wb_cycle_i;
`ifdef SRAM_CTRL_TURNAROUND_EN
          state_next = RECOVER;
`else
          state_next = IDLE;
`endif
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      WRITE: begin
        if (cnt_reg == '0) begin
          // Data bus stays driven into RECOVER so data outlives the WE edge.
          we_next    = 1'b0;
          ack_next   = wb_cycle_i;
          state_next = RECOVER;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      RECOVER: begin
        doe_next   = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers with synchronous reset that aborts any access.
  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      oe_reg    <= 1'b0;
      we_reg    <= 1'b0;
      doe_reg   <= 1'b0;
      ack_reg   <= 1'b0;
      be_reg    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      oe_reg    <= oe_next;
      we_reg    <= we_next;
      doe_reg   <= doe_next;
      ack_reg   <= ack_next;
      be_reg    <= be_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
    end
  end

  assign wb_stall_o  = (state_reg != IDLE);
  assign wb_ack_o    = ack_reg;
  assign wb_data_o   = rdata_reg;
  assign ram_oe_o    = oe_reg;
  assign ram_we_o    = we_reg;
  assign ram_data_oe = doe_reg;
  assign ram_be_o    = be_reg;
  assign ram_addr_o  = addr_reg;
  assign ram_data_o  = wdata_reg;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: runs two sram_ctrl configurations side by side
// (defaults: 1 access cycle, 8 bit; 100 MHz/25 ns: 3 access cycles, 16 bit)
// against a cycle-window model of the bus/SRAM timing.
`timescale 1ns/1ps

module tb_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input int cfg, input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL cfg%0d %s: got %0h, want %0h (t=%0t)", cfg, tag, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int MHZ = (gi == 0) ? 64 : 100;
    localparam int NS  = (gi == 0) ? 10 : 25;
    localparam int DW  = (gi == 0) ? 8 : 16;
    localparam int AW  = 17;
    localparam int SW  = DW / 8;
    localparam int ACR = (NS * MHZ + 999) / 1000;
    localparam int AC  = (ACR < 1) ? 1 : ACR;
`ifdef SRAM_CTRL_TURNAROUND_EN
    localparam int RD_GAP = AC + 3;
`else
    localparam int RD_GAP = AC + 2;
`endif
    // Hand-computed figures for each configuration.
    localparam int RD_LAT_HAND = (gi == 0) ? 2 : 4;
    localparam int WR_LAT_HAND = (gi == 0) ? 1 : 3;
    localparam logic [DW-1:0] BEEF_DATA = DW'(32'hBEEF);
    localparam logic [SW-1:0] BEEF_SEL  = SW'((gi == 0) ? 1 : 2);
    localparam logic [DW-1:0] BEEF_EXP  = DW'((gi == 0) ? 32'hEF : 32'hBE85);
    localparam logic [DW-1:0] A5_EXP    = DW'((gi == 0) ? 32'hA5 : 32'hA5A5);
    localparam logic [DW-1:0] E5_EXP    = DW'((gi == 0) ? 32'hE5 : 32'hE5E5);
    localparam logic [DW-1:0] V11       = DW'(32'h11);

    logic          srst, cyc, stb, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] sel;
    logic          stall, ack, ram_oe, ram_we, ram_doe;
    logic [SW-1:0] ram_be;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;
    logic [DW-1:0] sram_mem [256];
    bit            done_b = 1'b0;

    sram_ctrl #(
      .WB_CLOCK_MHZ(MHZ), .ACCESS_NS(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
    ) u_dut (
      .wb_clock_i(clk), .wb_reset_i(srst), .wb_addr_i(addr), .wb_data_i(wdata),
      .wb_data_o(rdata), .wb_sel_i(sel), .wb_we_i(we), .wb_cycle_i(cyc),
      .wb_strobe_i(stb), .wb_stall_o(stall), .wb_ack_o(ack), .ram_oe_o(ram_oe),
      .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_addr_o(ram_addr),
      .ram_data_i(ram_din), .ram_data_o(ram_dout), .ram_data_oe(ram_doe)
    );

    // Board SRAM: drives data only while OE is high, writes lanes while WE is high.
    assign ram_din = ram_oe ? sram_mem[ram_addr[7:0]] : {SW{8'h5C}};
    initial begin
      for (int i = 0; i < 256; i++) sram_mem[i] = {SW{8'(i) ^ 8'hA5}};
      forever begin
        @(negedge clk);
        if (ram_we)
          for (int b = 0; b < SW; b++)
            if (ram_be[b]) sram_mem[ram_addr[7:0]][b*8 +: 8] = ram_dout[b*8 +: 8];
      end
    end

    // Reference model: each accepted request owns a window of edges.
    initial begin : model
      int e, n_acc, ack_edge, free_edge;
      bit rd_op, wr_op, ack_cyc, rst_pend;
      logic [AW-1:0] x_addr;
      logic [SW-1:0] x_be;
      logic [DW-1:0] x_wdata, x_rdata;
      logic [DW-1:0] ref_mem [256];
      for (int i = 0; i < 256; i++) ref_mem[i] = {SW{8'(i) ^ 8'hA5}};
      e = 0; n_acc = -1000; ack_edge = -1; free_edge = 0;
      rd_op = 0; wr_op = 0; ack_cyc = 0; rst_pend = 0;
      x_addr = '0; x_be = '0; x_wdata = '0; x_rdata = '0;
      forever begin
        @(posedge clk);
        e++;
        @(negedge clk);
        if (rst_pend) begin
          rd_op = 0; wr_op = 0; n_acc = -1000; ack_edge = -1; free_edge = 0;
          x_addr = '0; x_be = '0; x_wdata = '0; x_rdata = '0;
        end else if (rd_op && e == n_acc + AC + 1) begin
          x_rdata = ref_mem[x_addr[7:0]];
        end
        check(gi, "ram_oe",   ram_oe,  rd_op && e >= n_acc && e <= n_acc + AC);
        check(gi, "ram_we",   ram_we,  wr_op && e >= n_acc && e <= n_acc + AC - 1);
        check(gi, "data_oe",  ram_doe, wr_op && e >= n_acc && e <= n_acc + AC);
        check(gi, "ack",      ack,     e == ack_edge && ack_cyc);
        check(gi, "stall",    stall,   e + 1 < free_edge);
        check(gi, "ram_addr", ram_addr, x_addr);
        check(gi, "ram_be",   ram_be,   x_be);
        check(gi, "ram_dout", ram_dout, x_wdata);
        check(gi, "wb_data",  rdata,    x_rdata);
        // Plan the coming edge from the inputs now stable on the bus.
        rst_pend = srst;
        if (!srst && e + 1 == ack_edge) ack_cyc = cyc;
        if (!srst && cyc && stb && !(e + 1 < free_edge)) begin
          n_acc   = e + 1;
          rd_op   = !we;
          wr_op   = we;
          x_addr  = addr;
          x_be    = sel;
          x_wdata = wdata;
          free_edge = n_acc + (we ? AC + 2 : RD_GAP);
          ack_edge  = we ? n_acc + AC : n_acc + AC + 1;
          if (we)
            for (int b = 0; b < SW; b++)
              if (sel[b]) ref_mem[addr[7:0]][b*8 +: 8] = wdata[b*8 +: 8];
        end
      end
    end

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
      bit ok;
      ok = 0;
      cyc = 1; stb = 1; we = w; addr = a; wdata = d; sel = s;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        ok = !stall;
        @(posedge clk);
        #1;
        if (ok) break;
      end
      stb = 0;
      check(gi, "accepted", ok, 1'b1);
      $display("cfg%0d %s addr=%05h data=%0h sel=%b at %0t", gi, w ? "WR" : "RD", a, d, s, $time);
    endtask

    task automatic wait_ack(input string tag, input int want);
      int lat;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk);
        #1;
        if (ack) begin
          lat = k;
          break;
        end
      end
      check(gi, tag, lat, want);
    endtask

    initial begin : stim
      int acks;
      srst = 1; cyc = 0; stb = 0; we = 0; addr = '0; wdata = '0; sel = '0;
      repeat (3) @(posedge clk);
      #1;
      check(gi, "rst_stall", stall, 1'b0);
      check(gi, "rst_oe", ram_oe, 1'b0);
      srst = 0;

      issue(1'b0, 17'h1_0000, '0, '1);
      wait_ack("rd_latency", RD_LAT_HAND);
      check(gi, "rd_a5", rdata, A5_EXP);

      issue(1'b1, 17'h0_0010, DW'(32'h11), '1);
      issue(1'b1, 17'h0_0011, DW'(32'h22), '1);
      wait_ack("wr_latency", WR_LAT_HAND);

      issue(1'b1, 17'h0_0020, BEEF_DATA, BEEF_SEL);
      check(gi, "be_lanes", ram_be, BEEF_SEL);
      wait_ack("wr_sel_latency", WR_LAT_HAND);
      issue(1'b0, 17'h0_0020, '0, '1);
      wait_ack("rd_after_wr_latency", RD_LAT_HAND);
      check(gi, "rd_beef", rdata, BEEF_EXP);

      issue(1'b0, 17'h0_0010, '0, '1);
      wait_ack("rd_0x10_latency", RD_LAT_HAND);
      check(gi, "rd_11", rdata, V11);

      issue(1'b0, 17'h0_0030, '0, '1);
      @(posedge clk);
      #1;
      cyc = 0;
      acks = 0;
      for (int k = 0; k < AC + 3; k++) begin
        @(posedge clk);
        #1;
        acks += int'(ack);
      end
      check(gi, "dropped_cycle_acks", acks, 0);
      issue(1'b0, 17'h0_0040, '0, '1);
      wait_ack("rd_after_drop_latency", RD_LAT_HAND);
      check(gi, "rd_e5", rdata, E5_EXP);

      issue(1'b1, 17'h0_0050, DW'(32'h77), '1);
      srst = 1;
      @(posedge clk);
      #1;
      check(gi, "rstmid_we", ram_we, 1'b0);
      check(gi, "rstmid_doe", ram_doe, 1'b0);
      check(gi, "rstmid_stall", stall, 1'b0);
      check(gi, "rstmid_ack", ack, 1'b0);
      srst = 0;

      issue(1'b0, 17'h0_0011, '0, '1);
      issue(1'b1, 17'h0_0060, DW'(32'h33), '1);
      repeat (10) @(posedge clk);
      #1;
      done_b = 1'b1;
    end
  end

  initial begin : summary
    fork
      wait (g_cfg[0].done_b && g_cfg[1].done_b);
      #200000;
    join_any
    if (!(g_cfg[0].done_b && g_cfg[1].done_b)) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: stimulus did not complete");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Wishbone B4 pipelined peripheral that drives an external asynchronous SRAM.
- Successor to the single-byte fixed-timing RAM controller.
- Generalises data width with byte lanes and derives access wait states from clock frequency and SRAM access time.
- Guarantees address-stable WE pulses and a data-bus recovery cycle after writes.
- Sits between the Wishbone interconnect and the board SRAM pins.

Parameters:
- WB_CLOCK_MHZ, 64: Wishbone clock frequency in MHz.
- ACCESS_NS, 10: SRAM read access / write pulse time in ns.
- DATA_WIDTH, 8: data width; must be a multiple of 8.
- ADDR_WIDTH, 17: word address width.
- SEL_WIDTH, DATA_WIDTH/8: number of byte lanes (derived; do not override).
- ACCESS_CYCLES (localparam): max(1, ceil(ACCESS_NS*WB_CLOCK_MHZ/1000)).

Ports:
- wb_clock_i  in  1  Wishbone clock; sole clock.
- wb_reset_i  in  1  synchronous, active-high reset.
- wb_addr_i  in  ADDR_WIDTH  word address.
- wb_data_i  in  DATA_WIDTH  write data.
- wb_data_o  out  DATA_WIDTH  read data; valid when wb_ack_o is high.
- wb_sel_i  in  SEL_WIDTH  byte enables.
- wb_we_i  in  1  1 = write.
- wb_cycle_i  in  1  bus cycle.
- wb_strobe_i  in  1  request strobe.
- wb_stall_o  out  1  high when a request cannot be accepted.
- wb_ack_o  out  1  one-cycle completion pulse.
- ram_oe_o  out  1  SRAM output enable (active high).
- ram_we_o  out  1  SRAM write enable (active high).
- ram_be_o  out  SEL_WIDTH  SRAM byte enables (active high).
- ram_addr_o  out  ADDR_WIDTH  SRAM address.
- ram_data_i  in  DATA_WIDTH  SRAM read data.
- ram_data_o  out  DATA_WIDTH  SRAM write data.
- ram_data_oe  out  1  FPGA drives the data bus.

Behaviour:
- Clock and reset: one clock, wb_clock_i. Reset wb_reset_i is synchronous, active-high.
- Reset values: state=IDLE; ram_oe_o=0, ram_we_o=0, ram_data_oe=0, wb_ack_o=0; ram_be_o=0, ram_addr_o=0, ram_data_o=0, wb_data_o=0.
- Power-up initial values match the reset values.
- Reset mid-operation: on the reset edge, all strobes drop and the FSM goes to IDLE; no ack is issued for the aborted cycle.
- wb_stall_o = (state != IDLE), combinational from the state register.
- Acceptance: a request is accepted at the edge where wb_cycle_i & wb_strobe_i & !wb_stall_o. Call this edge N.
- At acceptance, latch addr, data and sel into the ram_* outputs. ram_be_o = wb_sel_i for both reads and writes.
- ram_addr_o, ram_be_o and ram_data_o stay constant until the next acceptance.
- IDLE state:
  - On a read request: ram_oe_o<=1, cnt<=ACCESS_CYCLES, go to READ.
  - On a write request: ram_we_o<=1, ram_data_oe<=1, cnt<=ACCESS_CYCLES-1, go to WRITE.
- READ state: each edge, if cnt==0 then wb_data_o<=ram_data_i, ram_oe_o<=0, ack, go to IDLE; otherwise cnt--.
  - OE is high for ACCESS_CYCLES+1 cycles.
  - Ack arrives at edge N+ACCESS_CYCLES+1.
- WRITE state: each edge, if cnt==0 then ram_we_o<=0, ack, go to RECOVER (ram_data_oe stays high); otherwise cnt--.
  - WE pulse lasts ACCESS_CYCLES cycles.
  - Ack arrives at edge N+ACCESS_CYCLES.
- RECOVER state: ram_data_oe<=0, go to IDLE.
  - Data is held one cycle past WE falling.
  - WE never stays high across an address change.
- Throughput: earliest next acceptance is N+ACCESS_CYCLES+2 for both reads and writes.
- wb_ack_o is high for exactly one cycle.
  - It is gated by wb_cycle_i at the ack edge: if the cycle was dropped, the SRAM access still completes with full timing but no ack is issued.
- ram_oe_o and ram_we_o are never high simultaneously.
- ram_data_oe and ram_oe_o are never high simultaneously.
- Counter width is $clog2(ACCESS_CYCLES+1), and it must not wrap.

Optional Feature:
- Macro: SRAM_CTRL_TURNAROUND_EN.
- When defined: READ completion goes to RECOVER instead of IDLE. This adds one stall cycle so the SRAM output can return to High-Z before any following write drives the bus. Read throughput becomes one access per ACCESS_CYCLES+3 cycles.
- When undefined: READ returns directly to IDLE, as described above.

Test Plan:
- Defaults (ACCESS_CYCLES=1), read at 0x1_0000 with SRAM model returning 0xA5: OE high at edges N and N+1, ack with wb_data_o=0xA5 at N+2, stall low again after N+2.
- Defaults, back-to-back writes 0x11@0x00010 and 0x22@0x00011: WE high only at N, ack at N+1, ram_data_oe falls at N+2, second acceptance no earlier than N+3, ram_addr_o stable while WE is high.
- WB_CLOCK_MHZ=100, ACCESS_NS=25 (ACCESS_CYCLES=3), DATA_WIDTH=16, write 0xBEEF with sel=2'b10: ram_be_o=2'b10, WE high 3 cycles, ack at N+3; following read ack at its own N+4 returning the modelled value.
- Defaults, wb_cycle_i dropped one cycle after accepting a read: OE timing unchanged, no ack pulse, next request accepted normally.
- wb_reset_i asserted during WRITE with cnt>0 (ACCESS_CYCLES=3): next edge has WE=0, data_oe=0, stall=0, no ack.
- SRAM_CTRL_TURNAROUND_EN defined, read then write at defaults: read ack at N+2, stall high through N+2, write accepted at N+4 earliest, ram_data_oe low until then.
